nco_mc_qw: RTL and testbench

- Time-division-multiplexed, multi-channel sin/cos NCO. It is the parametrised successor to the single-channel NCO in the DDC chain.
- Serves NCH independent channels, one per enabled clock slot. Each channel has its own phase increment and phase offset.
- Frequency/offset changes are staged in shadow registers and committed atomically at a frame boundary. A synchronous phase clear is also provided.
- Uses a single quarter-wave sine ROM with symmetry folding, so no full-wave sin and cos tables are needed.

---
 rtl/nco_mc_qw.sv | 143 ++++++++++++++
 tb/tb_nco_mc_qw.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nco_mc_qw.sv
// Time-multiplexed sin/cos NCO: NCH channels share one accumulator path and one quarter-wave ROM.
// ROM contents are generated at elaboration from the same formula as ROM_FILE.
module nco_mc_qw #(
  parameter int    NCH      = 4,
  parameter int    APR      = 32,
  parameter int    LUTW     = 10,
  parameter int    MPR      = 16,
  parameter string ROM_FILE = "nco_qw.hex",
  localparam int   CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [CHW-1:0]        cfg_addr,
  input  logic [APR-1:0]        cfg_data,
  input  logic                  cfg_commit,
  input  logic                  phase_clr,
  output logic signed [MPR-1:0] fsin_o,
  output logic signed [MPR-1:0] fcos_o,
  output logic [CHW-1:0]        ch_o,
  output logic                  out_valid,
  output logic                  commit_pend
);
  localparam int  PW   = LUTW + 2;
  localparam int  NLUT = 2 ** LUTW;
  localparam real PI   = 3.14159265358979323846;

  function automatic logic signed [MPR-1:0] qw_entry(input int idx);
    real amp, val;
    amp = real'((longint'(1) << (MPR - 1)) - 1);
    val = amp * $sin(2.0 * PI * (real'(idx) + 0.5) / real'(4 * NLUT));
    return MPR'($rtoi(val + 0.5));
  endfunction

  function automatic logic signed [MPR-1:0] apply_sign(input logic signed [MPR-1:0] mag,
                                                       input logic neg);
    return neg ? -mag : mag;
  endfunction

  logic signed [MPR-1:0] rom [NLUT];
  for (genvar g = 0; g < NLUT; g++) begin : g_rom
    assign rom[g] = qw_entry(g);
  end

  logic [APR-1:0] shadow_inc [NCH];
  logic [APR-1:0] shadow_off [NCH];
  logic [APR-1:0] inc_act    [NCH];
  logic [APR-1:0] off_act    [NCH];
  logic [APR-1:0] acc        [NCH];
  logic [CHW-1:0] ch_cnt;
  logic           frame_end;
  logic           apply;

  logic [PW-1:0]         ph_p0;
  logic [CHW-1:0]        ch_p0, ch_p1, ch_p2;
  logic                  vld_p0, vld_p1, vld_p2;
  logic [LUTW-1:0]       sin_addr_p1, cos_addr_p1;
  logic                  sin_neg_p1, cos_neg_p1, sin_neg_p2, cos_neg_p2;
  logic signed [MPR-1:0] sin_mag_p2, cos_mag_p2;
  logic [1:0]            quad;
  logic [LUTW-1:0]       idx;

  assign frame_end = (ch_cnt == CHW'(NCH - 1));
  // A phase clear also counts as a frame boundary so a pending commit is not stranded.
  assign apply     = clken && commit_pend && (phase_clr || frame_end);
  assign quad      = ph_p0[PW-1 -: 2];
  assign idx       = ph_p0[LUTW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        shadow_inc[k] <= '0;
        shadow_off[k] <= '0;
        inc_act[k]    <= '0;
        off_act[k]    <= '0;
        acc[k]        <= '0;
      end
      ch_cnt      <= '0;
      commit_pend <= 1'b0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      out_valid   <= 1'b0;
      fsin_o      <= '0;
      fcos_o      <= '0;
      ch_o        <= '0;
    end else begin
      if (cfg_we) begin
        if (cfg_sel) shadow_off[cfg_addr] <= cfg_data;
        else         shadow_inc[cfg_addr] <= cfg_data;
      end
      commit_pend <= cfg_commit || (commit_pend && !apply);
      if (apply) begin
        inc_act <= shadow_inc;
        off_act <= shadow_off;
      end
      if (clken) begin
        if (phase_clr) begin
          for (int k = 0; k < NCH; k++) acc[k] <= '0;
          ch_cnt    <= '0;
          vld_p0    <= 1'b0;
          vld_p1    <= 1'b0;
          vld_p2    <= 1'b0;
          out_valid <= 1'b0;
        end else begin
          acc[ch_cnt] <= acc[ch_cnt] + inc_act[ch_cnt];
          ch_cnt      <= frame_end ? '0 : ch_cnt + CHW'(1);
          vld_p0      <= 1'b1;
          vld_p1      <= vld_p0;
          vld_p2      <= vld_p1;
          out_valid   <= vld_p2;
        end
        // stage 3: sign restore and output register
        fsin_o <= apply_sign(sin_mag_p2, sin_neg_p2);
        fcos_o <= apply_sign(cos_mag_p2, cos_neg_p2);
        ch_o   <= ch_p2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clken) begin
      // stage 0: phase = accumulator + offset, keep only the ROM-addressing bits
      ph_p0       <= PW'((acc[ch_cnt] + off_act[ch_cnt]) >> (APR - PW));
      ch_p0       <= ch_cnt;
      // stage 1: fold to first quadrant; cosine is sine one quadrant ahead
      sin_addr_p1 <= quad[0] ? ~idx : idx;
      cos_addr_p1 <= quad[0] ? idx : ~idx;
      sin_neg_p1  <= quad[1];
      cos_neg_p1  <= quad[1] ^ quad[0];
      ch_p1       <= ch_p0;
      // stage 2: registered dual ROM read
      sin_mag_p2  <= rom[sin_addr_p1];
      cos_mag_p2  <= rom[cos_addr_p1];
      sin_neg_p2  <= sin_neg_p1;
      cos_neg_p2  <= cos_neg_p1;
      ch_p2       <= ch_p1;
    end
  end

endmodule

// File: tb/tb_nco_mc_qw.sv
// Bench for nco_mc_qw: driver runs a channel-level NCO model and queues expected samples;
// a monitor pops them whenever the DUT advances and checks hold behaviour otherwise.
module tb_nco_mc_qw;
  localparam int  NCH  = 4;
  localparam int  APR  = 32;
  localparam int  LUTW = 10;
  localparam int  MPR  = 16;
  localparam int  CHW  = 2;
  localparam real PI   = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b1;
  logic                  clken = 1'b0;
  logic                  cfg_we = 1'b0;
  logic                  cfg_sel = 1'b0;
  logic [CHW-1:0]        cfg_addr = '0;
  logic [APR-1:0]        cfg_data = '0;
  logic                  cfg_commit = 1'b0;
  logic                  phase_clr = 1'b0;
  logic signed [MPR-1:0] fsin_o, fcos_o;
  logic [CHW-1:0]        ch_o;
  logic                  out_valid, commit_pend;

  nco_mc_qw #(.NCH(NCH), .APR(APR), .LUTW(LUTW), .MPR(MPR)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .phase_clr(phase_clr),
    .fsin_o(fsin_o), .fcos_o(fcos_o), .ch_o(ch_o), .out_valid(out_valid),
    .commit_pend(commit_pend)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int ch; int s; int c; } samp_t;
  samp_t sb[$];

  logic [APR-1:0] acc_m [NCH];
  logic [APR-1:0] inc_s [NCH];
  logic [APR-1:0] off_s [NCH];
  logic [APR-1:0] inc_a [NCH];
  logic [APR-1:0] off_a [NCH];
  int cnt_m = 0;
  bit pend_m = 1'b0;
  int n_edges = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ideal sample of sin/cos at the centre of the phase bin selected by the top LUTW+2 bits.
  function automatic int ref_val(input logic [APR-1:0] ph, input bit is_cos);
    real ang, v, a;
    int  mag;
    longint j;
    j   = longint'(ph >> (APR - LUTW - 2));
    ang = 2.0 * PI * (real'(j) + 0.5) / real'(longint'(1) << (LUTW + 2));
    v   = real'((longint'(1) << (MPR - 1)) - 1) * (is_cos ? $cos(ang) : $sin(ang));
    a   = (v < 0.0) ? -v : v;
    mag = $rtoi(a + 0.5);
    return (v < 0.0) ? -mag : mag;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      acc_m[k] = '0; inc_s[k] = '0; off_s[k] = '0; inc_a[k] = '0; off_a[k] = '0;
    end
    cnt_m = 0;
    pend_m = 1'b0;
    sb.delete();
  endtask

  task automatic step(input bit ce, input bit we, input bit sel, input int addr,
                      input logic [APR-1:0] data, input bit cm, input bit clr);
    bit app;
    logic [APR-1:0] ph;
    samp_t e;
    @(negedge clk); #1;
    clken = ce; cfg_we = we; cfg_sel = sel; cfg_addr = CHW'(addr);
    cfg_data = data; cfg_commit = cm; phase_clr = clr;
    app = 1'b0;
    if (ce) begin
      if (clr) begin
        sb.delete();
        for (int k = 0; k < NCH; k++) acc_m[k] = '0;
        app = pend_m;
        cnt_m = 0;
      end else begin
        ph = acc_m[cnt_m] + off_a[cnt_m];
        acc_m[cnt_m] = acc_m[cnt_m] + inc_a[cnt_m];
        e.idx = n_edges + 1; e.ch = cnt_m;
        e.s = ref_val(ph, 1'b0); e.c = ref_val(ph, 1'b1);
        sb.push_back(e);
        app = pend_m && (cnt_m == NCH - 1);
        cnt_m = (cnt_m + 1) % NCH;
      end
    end
    if (app) begin
      inc_a = inc_s;
      off_a = off_s;
    end
    if (we) begin
      if (sel) off_s[addr] = data;
      else     inc_s[addr] = data;
    end
    pend_m = cm || (pend_m && !app);
  endtask

  task automatic idle(input int n, input bit toggle);
    for (int i = 0; i < n; i++) step(toggle ? ((i % 2) == 0) : 1'b1, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0;
    clken = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; phase_clr = 1'b0;
    #1;
    check("rst_fsin", fsin_o, 0);
    check("rst_fcos", fcos_o, 0);
    check("rst_ch", ch_o, 0);
    check("rst_valid", out_valid, 0);
    check("rst_pend", commit_pend, 0);
    model_clear();
    @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Monitor: on advancing edges pop/compare; on stalled edges outputs must hold.
  logic signed [MPR-1:0] prev_sin = '0, prev_cos = '0;
  logic [CHW-1:0]        prev_ch = '0;
  logic                  prev_v = 1'b0;
  initial begin
    samp_t e;
    bit    exp_v;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (clken) begin
          n_edges++;
          exp_v = (sb.size() > 0) && (sb[0].idx + 3 == n_edges);
          check("out_valid", out_valid, exp_v);
          if (exp_v) begin
            e = sb.pop_front();
            check("ch_o", ch_o, e.ch);
            check("fsin_o", fsin_o, e.s);
            check("fcos_o", fcos_o, e.c);
          end
        end else begin
          check("hold_valid", out_valid, prev_v);
          check("hold_fsin", fsin_o, prev_sin);
          check("hold_fcos", fcos_o, prev_cos);
          check("hold_ch", ch_o, prev_ch);
        end
        check("commit_pend", commit_pend, pend_m);
      end
      prev_sin = fsin_o; prev_cos = fcos_o; prev_ch = ch_o; prev_v = out_valid;
    end
  end

  initial begin
    int r;
    #1 reset_n = 1'b0;
    model_clear();
    do_reset();

    // quarter-turn increment on channel 0, write and commit together
    step(1, 1, 0, 0, 32'h4000_0000, 1, 0);
    idle(24, 0);

    // half-turn offset, zero increment on channel 2
    step(1, 1, 1, 2, 32'h8000_0000, 0, 0);
    step(1, 1, 0, 2, 32'h0000_0000, 1, 0);
    idle(16, 0);

    // two channels retuned mid-frame, commit issued while slot 1 is active
    step(1, 1, 0, 1, 32'h1234_5678, 0, 0);
    step(1, 1, 0, 3, 32'h0F0F_0F0F, 0, 0);
    for (int i = 0; i < NCH && cnt_m != 1; i++) step(1, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, '0, 1, 0);
    idle(16, 0);

    // clock-enable gating 1010...
    idle(40, 1);

    // decrementing phase wraps through zero, then clear at slot 2
    step(1, 1, 0, 0, 32'hFFFF_FFFF, 1, 0);
    idle(20, 0);
    for (int i = 0; i < NCH && cnt_m != 2; i++) step(1, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 1);
    idle(12, 0);

    // clear with a commit pending applies the commit on the same edge
    step(1, 1, 1, 0, 32'h2000_0000, 1, 0);
    step(1, 0, 0, 0, '0, 0, 1);
    idle(10, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      step($urandom_range(0, 3) != 0, r < 20, 1'($urandom_range(0, 1)), $urandom_range(0, NCH - 1),
           $urandom, (r >= 15) && (r < 26), r >= 98);
    end
    idle(8, 0);

    // asynchronous reset in the middle of activity
    do_reset();
    idle(8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
